// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - requester and SRAM pin bundle for shared_mem_arbiter
interface shared_mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_dout_oe;
  logic [15:0] ram_din;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
           ram_en_n, ram_oe_n, ram_we_n, ram_addr, ram_dout, ram_dout_oe
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
           ram_en_n, ram_oe_n, ram_we_n, ram_addr, ram_dout, ram_dout_oe
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - IF/MEM arbiter sequencing setup/strobe/hold on one SRAM port
module shared_mem_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_MEM_BURST = 3
) (
  input logic                 CLK,
  input logic                 RST,
  shared_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [2:0] BURST_MAX   = 3'(MAX_MEM_BURST);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  strobe_cnt;
  logic [2:0]  burst;
  logic        g_mem;
  logic        g_we;
  logic [15:0] g_addr;
  logic [15:0] g_wdata;
  logic [15:0] if_rdata_r;
  logic [15:0] mem_rdata_r;

  logic mem_valid;
  logic arb_open;
  logic if_cand;
  logic mem_cand;
  logic grant_if;
  logic grant_mem;
  logic grant;
  logic last_strobe;

  // Arbitration: MEM first, unless IF has waited out a full MEM burst; the owner finishing in HOLD is excluded
  always_comb begin
    mem_valid   = bus.mem_rd ^ bus.mem_wr;
    arb_open    = (state == IDLE) || (state == HOLD);
    if_cand     = bus.if_req && !((state == HOLD) && !g_mem);
    mem_cand    = mem_valid && !((state == HOLD) && g_mem);
    grant_if    = arb_open && if_cand && (!mem_cand || (burst == BURST_MAX));
    grant_mem   = arb_open && mem_cand && !grant_if;
    grant       = grant_if || grant_mem;
    last_strobe = (state == STROBE) && (strobe_cnt == 4'd0);
  end

  // Access sequencer state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: back-to-back accesses go HOLD -> SETUP with no idle gap
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (strobe_cnt == 4'd0) state_nxt = HOLD;
      HOLD:    state_nxt = grant ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch so requester inputs may move while the access is in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      g_mem   <= 1'b0;
      g_we    <= 1'b0;
      g_addr  <= 16'h0000;
      g_wdata <= 16'h0000;
    end else if (grant) begin
      g_mem   <= grant_mem;
      g_we    <= grant_mem && bus.mem_wr;
      g_addr  <= grant_mem ? bus.mem_addr : bus.if_addr;
      g_wdata <= grant_mem ? bus.mem_wdata : 16'h0000;
    end
  end

  // Strobe length down-counter, loaded while in SETUP
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                   strobe_cnt <= 4'd0;
    else if (state == SETUP)                    strobe_cnt <= STROBE_LAST;
    else if (state == STROBE && strobe_cnt != 0) strobe_cnt <= strobe_cnt - 4'd1;
  end

  // Consecutive MEM grants while IF is requesting; saturates rather than wrapping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      burst <= 3'd0;
    end else if (grant_if) begin
      burst <= 3'd0;
    end else if (grant_mem) begin
      if (!bus.if_req)         burst <= 3'd0;
      else if (burst != 3'd7)  burst <= burst + 3'd1;
    end
  end

  // Read data captured on the last strobe edge, held until that requester's next read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      if_rdata_r  <= 16'h0000;
      mem_rdata_r <= 16'h0000;
    end else if (last_strobe && !g_we) begin
      if (g_mem) mem_rdata_r <= bus.ram_din;
      else       if_rdata_r  <= bus.ram_din;
    end
  end

  // Pin and handshake decode from the registered state
  always_comb begin
    bus.ram_en_n    = (state == IDLE);
    bus.ram_oe_n    = !((state == STROBE) && !g_we);
    bus.ram_we_n    = !((state == STROBE) && g_we);
    bus.ram_dout_oe = (state != IDLE) && g_we;
    bus.ram_addr    = {2'b00, g_addr};
    bus.ram_dout    = g_wdata;
    bus.if_rdata    = if_rdata_r;
    bus.mem_rdata   = mem_rdata_r;
    bus.if_done     = (state == HOLD) && !g_mem;
    bus.mem_done    = (state == HOLD) && g_mem;
    bus.if_stall    = bus.if_req && !bus.if_done;
    bus.mem_stall   = mem_valid && !bus.mem_done;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - scoreboard bench for shared_mem_arbiter
module tb_shared_mem_arbiter;

  localparam int S    = 2;
  localparam int MAXB = 3;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  logic CLK;
  logic RST;
  shared_mem_arbiter_if bus();

  shared_mem_arbiter #(.STROBE_CYCLES(S), .MAX_MEM_BURST(MAXB)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  req_t if_q[$];
  req_t mem_q[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] sram [0:65535];

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h6A05;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: contents latched on the rising edge of WE_n during a live access
  assign bus.ram_din = sram[bus.ram_addr[15:0]];
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = init_word(16'(i));
    forever begin
      @(posedge bus.ram_we_n);
      if (RST === 1'b1 && bus.ram_en_n === 1'b0) sram[bus.ram_addr[15:0]] = bus.ram_dout;
    end
  end

  task automatic do_if(input logic [15:0] a);
    bit seen;
    int t;
    req_t r;
    @(posedge CLK); #1;
    r.wr = 0; r.addr = a; r.data = init_word(a);
    if_q.push_back(r);
    bus.if_addr = a;
    bus.if_req  = 1;
    seen = 0; t = 0;
    while (!seen && t < 100) begin
      @(negedge CLK);
      t++;
      seen = bus.if_done;
    end
    chk("if_done_seen", 32'(seen), 1);
    @(posedge CLK); #1;
    bus.if_req  = 0;
    bus.if_addr = 16'($urandom);
  endtask

  task automatic do_mem(input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit seen;
    int t;
    req_t r;
    @(posedge CLK); #1;
    r.wr = wr; r.addr = a;
    if (wr) begin
      ref_mem[a[7:0]] = d;
      r.data = d;
    end else begin
      r.data = ref_mem[a[7:0]];
    end
    mem_q.push_back(r);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_rd    = !wr;
    bus.mem_wr    = wr;
    seen = 0; t = 0;
    while (!seen && t < 100) begin
      @(negedge CLK);
      t++;
      seen = bus.mem_done;
    end
    chk("mem_done_seen", 32'(seen), 1);
    @(posedge CLK); #1;
    bus.mem_rd    = 0;
    bus.mem_wr    = 0;
    bus.mem_addr  = 16'($urandom);
    bus.mem_wdata = 16'($urandom);
  endtask

  task automatic do_illegal(input int n);
    @(posedge CLK); #1;
    bus.mem_rd = 1;
    bus.mem_wr = 1;
    repeat (n) @(posedge CLK);
    #1;
    bus.mem_rd = 0;
    bus.mem_wr = 0;
  endtask

  // Monitor: transaction-level model of the port (who owns it, which cycle of the access) checked every cycle
  initial begin
    bit          m_busy;
    bit          m_mem;
    bit          m_done;
    bit          strb;
    bit          if_p;
    bit          mem_p;
    bit          pick_if;
    int          m_k;
    int          m_streak;
    req_t        m_cur;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_mem_rdata;
    m_busy = 0; m_mem = 0; m_k = 0; m_streak = 0;
    m_cur.wr = 0; m_cur.addr = 0; m_cur.data = 0;
    exp_if_rdata = 0; exp_mem_rdata = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        m_done = m_busy && (m_k + 1 == S + 2);
        if (m_busy) begin
          m_k++;
          strb = (m_k >= 2) && (m_k <= S + 1);
          chk("ram_en_n", 32'(bus.ram_en_n), 0);
          chk("ram_addr", 32'(bus.ram_addr), 32'({2'b00, m_cur.addr}));
          chk("ram_oe_n", 32'(bus.ram_oe_n), 32'(!(strb && !m_cur.wr)));
          chk("ram_we_n", 32'(bus.ram_we_n), 32'(!(strb && m_cur.wr)));
          chk("ram_dout_oe", 32'(bus.ram_dout_oe), 32'(m_cur.wr));
          if (m_cur.wr) chk("ram_dout", 32'(bus.ram_dout), 32'(m_cur.data));
        end else begin
          chk("idle_en_n", 32'(bus.ram_en_n), 1);
          chk("idle_oe_n", 32'(bus.ram_oe_n), 1);
          chk("idle_we_n", 32'(bus.ram_we_n), 1);
          chk("idle_dout_oe", 32'(bus.ram_dout_oe), 0);
        end
        if (m_done && !m_cur.wr) begin
          if (m_mem) exp_mem_rdata = m_cur.data;
          else       exp_if_rdata  = m_cur.data;
        end
        chk("if_done", 32'(bus.if_done), 32'(m_done && !m_mem));
        chk("mem_done", 32'(bus.mem_done), 32'(m_done && m_mem));
        chk("if_rdata", 32'(bus.if_rdata), 32'(exp_if_rdata));
        chk("mem_rdata", 32'(bus.mem_rdata), 32'(exp_mem_rdata));
        chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !(m_done && !m_mem)));
        chk("mem_stall", 32'(bus.mem_stall),
            32'((bus.mem_rd ^ bus.mem_wr) && !(m_done && m_mem)));
        if (!m_busy || m_done) begin
          if_p  = bus.if_req && !(m_done && !m_mem);
          mem_p = (bus.mem_rd ^ bus.mem_wr) && !(m_done && m_mem);
          pick_if = (if_p && mem_p) ? (m_streak == MAXB) : if_p;
          if (if_p || mem_p) begin
            if (pick_if) begin
              m_streak = 0;
              m_mem = 0;
              chk("if_q_nonempty", 32'(if_q.size() > 0), 1);
              if (if_q.size() > 0) m_cur = if_q.pop_front();
            end else begin
              m_streak = bus.if_req ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
              m_mem = 1;
              chk("mem_q_nonempty", 32'(mem_q.size() > 0), 1);
              if (mem_q.size() > 0) m_cur = mem_q.pop_front();
            end
            m_busy = 1;
            m_k = 0;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
  end

  // Stimulus: directed reset/abort case, then directed and random traffic under the monitor
  initial begin
    int  t;
    int  stall_cycles;
    bit  seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word({8'h10, 8'(i)});
    RST = 0;
    bus.if_req = 0;    bus.if_addr = 0;
    bus.mem_rd = 0;    bus.mem_wr = 0;
    bus.mem_addr = 0;  bus.mem_wdata = 0;
    repeat (3) @(negedge CLK);
    chk("rst_en_n", 32'(bus.ram_en_n), 1);
    chk("rst_oe_n", 32'(bus.ram_oe_n), 1);
    chk("rst_we_n", 32'(bus.ram_we_n), 1);
    chk("rst_dout_oe", 32'(bus.ram_dout_oe), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 0);
    chk("rst_if_rdata", 32'(bus.if_rdata), 0);
    chk("rst_mem_rdata", 32'(bus.mem_rdata), 0);
    chk("rst_if_done", 32'(bus.if_done), 0);
    chk("rst_mem_done", 32'(bus.mem_done), 0);
    RST = 1;

    // Write aborted by reset during its strobe
    @(posedge CLK); #1;
    bus.mem_wr = 1; bus.mem_addr = 16'h1234; bus.mem_wdata = 16'hBEEF;
    seen = 0; t = 0;
    while (!seen && t < 20) begin
      @(negedge CLK);
      t++;
      seen = (bus.ram_we_n == 1'b0);
    end
    chk("abort_strobe_seen", 32'(seen), 1);
    #2 RST = 0;
    #1;
    chk("abort_we_n", 32'(bus.ram_we_n), 1);
    chk("abort_dout_oe", 32'(bus.ram_dout_oe), 0);
    chk("abort_en_n", 32'(bus.ram_en_n), 1);
    chk("abort_mem_done", 32'(bus.mem_done), 0);
    @(negedge CLK);
    bus.mem_wr = 0;
    repeat (2) @(negedge CLK);
    RST = 1;
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.mem_done || !bus.ram_en_n) seen = 1;
    end
    chk("abort_idle_after", 32'(seen), 0);
    mon_en = 1;

    // Both MEM strobes high: not a request
    do_illegal(6);
    repeat (2) @(posedge CLK);

    do_if(16'h0004);
    chk("if_rdata_6a01", 32'(bus.if_rdata), 32'h6A01);
    do_mem(1, 16'h1012, 16'hBEEF);
    do_mem(0, 16'h1012, 16'h0000);
    chk("mem_readback", 32'(bus.mem_rdata), 32'hBEEF);

    // Simultaneous reads: MEM first, IF straight after, IF stalled 8 cycles
    stall_cycles = 0;
    fork
      do_mem(0, 16'h1020, 16'h0000);
      do_if(16'h0031);
      begin
        @(posedge CLK); #1;
        t = 0;
        while (t < 40) begin
          @(negedge CLK);
          t++;
          if (bus.if_done) break;
          if (bus.if_stall) stall_cycles++;
        end
      end
    join
    chk("if_stall_cycles", 32'(stall_cycles), 8);

    // Random contention
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        do_if({8'h00, 8'($urandom)});
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        if ($urandom_range(0, 7) == 0) do_illegal(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 1) == 1) do_mem(1, {8'h10, 8'($urandom)}, 16'($urandom));
        else                           do_mem(0, {8'h10, 8'($urandom)}, 16'h0000);
      end
    join

    repeat (10) @(negedge CLK);
    chk("if_q_drained", 32'(if_q.size()), 0);
    chk("mem_q_drained", 32'(mem_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Arbitrates one external SRAM port between the instruction-fetch requester (IF) and the data-memory requester (MEM).
- Used when data accesses target instruction space, so both share the RAM2 chip.
- Sequences each access as setup/strobe/hold on a single clock, replacing the CLK/CLK_half phase trick.
- Generates per-requester stalls for the pipeline hazard unit.

Parameters:
- STROBE_CYCLES, 2, cycles OE_n/WE_n held low per access (1..15).
- MAX_MEM_BURST, 3, consecutive MEM grants allowed while IF waits before IF is forced in (1..7).

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request, held until if_done
- if_addr  in  16  IF word address
- if_rdata  out  16  fetched instruction, valid when if_done=1
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req && !if_done (combinational)
- mem_rd  in  1  MEM read request, held until mem_done
- mem_wr  in  1  MEM write request, held until mem_done
- mem_addr  in  16  MEM word address
- mem_wdata  in  16  write data
- mem_rdata  out  16  read data, valid when mem_done=1
- mem_done  out  1  one-cycle completion pulse
- mem_stall  out  1  (mem_rd^mem_wr) && !mem_done (combinational)
- ram_en_n  out  1  chip enable, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, active-low
- ram_addr  out  18  {2'b0, granted addr}
- ram_dout  out  16  data driven to pad
- ram_dout_oe  out  1  1 = drive ram_dout onto the pad (top level builds the tristate)
- ram_din  in  16  data from pad

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; ram_en_n=1, ram_oe_n=1, ram_we_n=1, ram_dout_oe=0, ram_addr=0, ram_dout=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, burst counter=0. Reset mid-access aborts immediately; strobes deassert in the same instant and no done pulse is issued.
- Valid MEM request: exactly one of mem_rd/mem_wr high. Both high is treated as no request: not granted, mem_stall=0.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If any valid request is present, latch the grant (owner, we, addr, wdata) and go to SETUP. Otherwise stay.
- SETUP (1 cycle):
  - ram_en_n=0, ram_addr valid, strobes high.
  - If write: ram_dout_oe=1, ram_dout=wdata.
- STROBE (STROBE_CYCLES cycles, counted by a 4-bit down-counter):
  - ram_en_n=0; read: ram_oe_n=0; write: ram_we_n=0, ram_dout_oe=1.
  - On the last strobe cycle edge, a read captures ram_din into the owner's rdata register.
- HOLD (1 cycle):
  - Strobes high, ram_en_n=0, addr and data held (write hold time).
  - Owner's done=1 for exactly this cycle.
  - Re-arbitrate in this cycle: if a valid request other than the one just completed is pending, latch it and go to SETUP. Otherwise go to IDLE.
  - The just-completed requester drops its request after seeing done; its request is ignored in this HOLD cycle.
- Access latency: request seen in IDLE → done is asserted STROBE_CYCLES+2 cycles later. Back-to-back accesses occupy STROBE_CYCLES+2 cycles each, with no IDLE gap.
- Arbitration:
  - MEM has priority, since it is the older instruction.
  - Burst counter (3 bits): increments on each MEM grant while if_req=1; clears on any IF grant, or when if_req=0 at a grant.
  - When counter==MAX_MEM_BURST and if_req=1, IF wins over MEM. The counter saturates; it does not wrap.
- Grant latching: requester inputs may change after grant without affecting the in-flight access.
- rdata registers hold their value until the next read completion for that requester.
- ram_oe_n and ram_we_n are never low simultaneously. ram_dout_oe is never 1 during a read.

Test Plan:
- Reset mid-strobe: assert RST=0 during a write STROBE → ram_we_n=1 and ram_dout_oe=0 immediately; no mem_done; IDLE after release.
- Single IF read (STROBE_CYCLES=2): if_addr=16'h0004, ram_din=16'h6A01 → if_done pulses 4 cycles after the request; if_rdata=16'h6A01; ram_addr=18'h00004; ram_oe_n low for exactly 2 cycles.
- MEM write: mem_wr=1, mem_addr=16'h1234, mem_wdata=16'hBEEF → ram_we_n low 2 cycles; ram_dout_oe=1 across SETUP/STROBE/HOLD; ram_oe_n stays 1; mem_done pulses once.
- Simultaneous IF+MEM reads → MEM served first; IF served immediately after (SETUP directly after HOLD); if_stall=1 for 8 cycles.
- Starvation (MAX_MEM_BURST=3): mem_rd held continuously with new addresses plus if_req=1 → grant order MEM, MEM, MEM, IF, MEM…
- Illegal mem_rd=mem_wr=1 with if_req=0 → no strobes; mem_stall=0; state stays IDLE.
